// File: rtl/cmd_pts_wrapper_if.sv
// rtl/cmd_pts_wrapper_if.sv - command/handshake bundle between CMD serializer and its controller
interface cmd_pts_wrapper_if;
    logic        enable_pts_wrapper;
    logic        load_send;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_argument;
    logic        cmd_out;
    logic        transmission_complete;

    modport master (
        output enable_pts_wrapper,
        output load_send,
        output cmd_index,
        output cmd_argument,
        input  cmd_out,
        input  transmission_complete
    );

    modport slave (
        input  enable_pts_wrapper,
        input  load_send,
        input  cmd_index,
        input  cmd_argument,
        output cmd_out,
        output transmission_complete
    );
endinterface

// File: rtl/cmd_pts_wrapper.sv
// rtl/cmd_pts_wrapper.sv - parallel-to-serial SD command framer with CRC7 and end bit
module cmd_pts_wrapper #(
    parameter int FRAME_BITS = 48,
    parameter int CRC_BITS   = 7
) (
    input  logic              sd_clock,
    input  logic              reset,
    input  logic              reset_wrapper,
    cmd_pts_wrapper_if.slave  bus
);

    // Start bit + transmission bit + index + argument; CRC and end bit follow.
    localparam int PAYLOAD_BITS = FRAME_BITS - CRC_BITS - 1;

    localparam logic [5:0]          PAYLOAD_END = 6'(PAYLOAD_BITS);
    localparam logic [5:0]          FRAME_LAST  = 6'(FRAME_BITS - 1);
    localparam logic [CRC_BITS-1:0] CRC_POLY    = CRC_BITS'(7'h09);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [5:0]              cnt_q, cnt_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic [CRC_BITS-1:0]     crc_q, crc_d;
    logic                    cmd_out_q, cmd_out_d;
    logic                    done_q, done_d;

    // One serial CRC7 step (x^7 + x^3 + 1) for a single payload bit.
    function automatic logic [CRC_BITS-1:0] crc_step(input logic [CRC_BITS-1:0] crc,
                                                     input logic bit_in);
        logic fb;
        fb = crc[CRC_BITS-1] ^ bit_in;
        return {crc[CRC_BITS-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    endfunction

    // Next-state and serial output: payload MSB first, then CRC, then end bit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        crc_d     = crc_q;
        cmd_out_d = cmd_out_q;
        done_d    = done_q;

        if (!bus.enable_pts_wrapper) begin
            // Disabling throws away whatever frame was in flight.
            state_d   = IDLE;
            cnt_d     = '0;
            shift_d   = '0;
            crc_d     = '0;
            cmd_out_d = 1'b1;
            done_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cmd_out_d = 1'b1;
                    done_d    = 1'b0;
                    // A send request with nothing loaded is ignored.
                    if (!bus.load_send) begin
                        shift_d = {1'b0, 1'b1, bus.cmd_index, bus.cmd_argument};
                        crc_d   = '0;
                        cnt_d   = '0;
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    cmd_out_d = 1'b1;
                    if (!bus.load_send) begin
                        shift_d = {1'b0, 1'b1, bus.cmd_index, bus.cmd_argument};
                    end else begin
                        state_d = SEND;
                    end
                end
                SEND: begin
                    // load_send low pauses the frame with every register held.
                    if (bus.load_send) begin
                        cnt_d = cnt_q + 6'd1;
                        if (cnt_q < PAYLOAD_END) begin
                            cmd_out_d = shift_q[PAYLOAD_BITS-1];
                            shift_d   = {shift_q[PAYLOAD_BITS-2:0], 1'b0};
                            crc_d     = crc_step(crc_q, shift_q[PAYLOAD_BITS-1]);
                        end else if (cnt_q < FRAME_LAST) begin
                            // CRC is complete here; shift it out MSB first.
                            cmd_out_d = crc_q[CRC_BITS-1];
                            crc_d     = {crc_q[CRC_BITS-2:0], 1'b0};
                        end else begin
                            cmd_out_d = 1'b1;
                            done_d    = 1'b1;
                            state_d   = DONE;
                        end
                    end
                end
                DONE: begin
                    cmd_out_d = 1'b1;
                    done_d    = 1'b1;
                end
                default: begin
                    state_d   = IDLE;
                    cmd_out_d = 1'b1;
                    done_d    = 1'b0;
                end
            endcase
        end
    end

    // State register; either reset source wins over everything else.
    always_ff @(posedge sd_clock) begin
        if (reset || reset_wrapper) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            crc_q     <= '0;
            cmd_out_q <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            crc_q     <= crc_d;
            cmd_out_q <= cmd_out_d;
            done_q    <= done_d;
        end
    end

    assign bus.cmd_out               = cmd_out_q;
    assign bus.transmission_complete = done_q;

endmodule

// File: tb/tb_cmd_pts_wrapper.sv
// tb/tb_cmd_pts_wrapper.sv - scoreboard bench for cmd_pts_wrapper
module tb_cmd_pts_wrapper;

    logic sd_clock = 1'b0;
    logic reset;
    logic reset_wrapper;

    cmd_pts_wrapper_if bus ();

    cmd_pts_wrapper #(.FRAME_BITS(48), .CRC_BITS(7)) dut (
        .sd_clock      (sd_clock),
        .reset         (reset),
        .reset_wrapper (reset_wrapper),
        .bus           (bus)
    );

    always #5 sd_clock = ~sd_clock;

    typedef struct {
        logic [47:0] frame;
        int          edges;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge sd_clock);
    endtask

    // Monitor: assembles each serial frame from the pad and retires it against the scoreboard.
    logic        collecting = 1'b0;
    int          nbits      = 0;
    int          edges      = 0;
    logic [47:0] frame      = '0;

    always @(posedge sd_clock) begin
        logic ls;
        logic ab;
        exp_t e;
        ls = bus.load_send;
        ab = reset || reset_wrapper || !bus.enable_pts_wrapper;
        #1;
        if (ab) begin
            collecting = 1'b0;
        end else if (!collecting) begin
            if (bus.cmd_out === 1'b0) begin
                collecting = 1'b1;
                nbits      = 1;
                edges      = 1;
                frame      = '0;
                check("complete_early", 64'(bus.transmission_complete), 64'd0);
            end
        end else begin
            edges++;
            if (!ls) begin
                check("pause_hold", 64'(bus.cmd_out), 64'(frame[0]));
            end else begin
                frame = {frame[46:0], bus.cmd_out};
                nbits++;
                if (nbits < 48) begin
                    check("complete_early", 64'(bus.transmission_complete), 64'd0);
                end else begin
                    collecting = 1'b0;
                    if (sb.size() == 0) begin
                        check("unexpected_frame", 64'(frame), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("frame", 64'(frame), 64'(e.frame));
                        check("latency", 64'(edges), 64'(e.edges));
                        check("complete_at_end", 64'(bus.transmission_complete), 64'd1);
                    end
                end
            end
        end
    end

    // Loads one command, streams it with an optional pause, then exercises DONE and disable.
    task automatic send_frame(input logic [5:0] idx, input logic [31:0] arg,
                              input logic [47:0] exp_frame, input int pause_at, input int pause_len);
        exp_t e;
        e.frame = exp_frame;
        e.edges = 48 + pause_len;
        sb.push_back(e);
        bus.enable_pts_wrapper = 1'b1;
        bus.cmd_index          = 6'h3f;
        bus.cmd_argument       = 32'hffff_ffff;
        bus.load_send          = 1'b0;
        tick();
        bus.cmd_index    = idx;
        bus.cmd_argument = arg;
        tick();
        check("load_idle_high", 64'(bus.cmd_out), 64'd1);
        bus.load_send = 1'b1;
        tick();
        check("send_entry_high", 64'(bus.cmd_out), 64'd1);
        for (int k = 1; k <= 48 + pause_len; k++) begin
            bus.load_send = !(pause_len > 0 && k > pause_at + 1 && k <= pause_at + 1 + pause_len);
            tick();
        end
        bus.load_send = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        check("done_hold_complete", 64'(bus.transmission_complete), 64'd1);
        check("done_hold_cmd", 64'(bus.cmd_out), 64'd1);
        bus.enable_pts_wrapper = 1'b0;
        tick();
        check("disable_complete", 64'(bus.transmission_complete), 64'd0);
        check("disable_cmd", 64'(bus.cmd_out), 64'd1);
    endtask

    initial begin
        reset                  = 1'b1;
        reset_wrapper          = 1'b0;
        bus.enable_pts_wrapper = 1'b0;
        bus.load_send          = 1'b0;
        bus.cmd_index          = '0;
        bus.cmd_argument       = '0;
        tick();
        tick();
        check("reset_cmd", 64'(bus.cmd_out), 64'd1);
        check("reset_complete", 64'(bus.transmission_complete), 64'd0);
        reset = 1'b0;
        tick();

        send_frame(6'd0,  32'h0000_0000, 48'h400000000095, 0, 0);
        send_frame(6'd8,  32'h0000_01AA, 48'h48000001AA87, 0, 0);
        send_frame(6'd17, 32'h0000_0000, 48'h510000000055, 20, 5);

        // Abort partway through a frame with the wrapper clear.
        bus.enable_pts_wrapper = 1'b1;
        bus.cmd_index          = 6'd8;
        bus.cmd_argument       = 32'h0000_01AA;
        bus.load_send          = 1'b0;
        tick();
        bus.load_send = 1'b1;
        tick();
        for (int k = 0; k < 31; k++) tick();
        reset_wrapper = 1'b1;
        tick();
        reset_wrapper = 1'b0;
        check("abort_cmd", 64'(bus.cmd_out), 64'd1);
        check("abort_complete", 64'(bus.transmission_complete), 64'd0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("abort_no_resume", 64'(bus.cmd_out), 64'd1);
        end
        send_frame(6'd0, 32'h0000_0000, 48'h400000000095, 0, 0);

        // A send request with nothing loaded must keep the line idle.
        bus.enable_pts_wrapper = 1'b1;
        bus.load_send          = 1'b1;
        for (int k = 0; k < 60; k++) begin
            tick();
            check("no_load_idle", 64'(bus.cmd_out), 64'd1);
            check("no_load_complete", 64'(bus.transmission_complete), 64'd0);
        end

        for (int k = 0; k < 4; k++) tick();
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("monitor_idle", 64'(collecting), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmd_pts_wrapper.md
CMD_PTS_WRAPPER -- requirements
Module: cmd_pts_wrapper

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 48, meaning total command frame length in bits (fixed; other values unsupported).
REQ-002 SHALL have parameter CRC_BITS, default 7, meaning CRC7 field width.
REQ-003 SHALL have port sd_clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port reset_wrapper  input  1  synchronous wrapper clear from physical-layer control, same effect as reset.
REQ-006 SHALL have port enable_pts_wrapper  input  1  block enable; 0 aborts any frame.
REQ-007 SHALL have port load_send  input  1  0 = load frame, 1 = shift frame out.
REQ-008 SHALL have port cmd_index  input  6  command index, sampled at load.
REQ-009 SHALL have port cmd_argument  input  32  command argument, sampled at load.
REQ-010 SHALL have port cmd_out  output  1  registered serial CMD bit to pad, MSB first.
REQ-011 SHALL have port transmission_complete  output  1  frame fully driven, level.

Function
REQ-012 SHALL implement states IDLE, LOAD, SEND, DONE, with a 6-bit bit counter, a 40-bit shift register and a 7-bit CRC register.
REQ-013 In IDLE, enable_pts_wrapper=1 and load_send=0 SHALL capture {1'b0, 1'b1, cmd_index, cmd_argument} into the shift register, clear the CRC and counter, and go to LOAD.
REQ-014 In IDLE, enable_pts_wrapper=1 and load_send=1 SHALL remain in IDLE; a frame is never sent without a prior load.
REQ-015 In LOAD, load_send=0 SHALL hold LOAD, re-capturing cmd_index and cmd_argument each cycle; load_send=1 SHALL go to SEND with cmd_out still 1.
REQ-016 In SEND with load_send=1, each rising edge SHALL drive exactly one bit on cmd_out and increment the counter.
REQ-017 Bits 0..39 SHALL be the shift register MSB; bits 40..46 SHALL be CRC[6..0]; bit 47 SHALL be 1 (end bit).
REQ-018 CRC7 SHALL use polynomial x^7+x^3+1 with init 0, updated per bit b of bits 0..39 as fb=crc[6]^b, crc={crc[5:0],0}^(fb?7'h09:0).
REQ-019 The edge that drives bit 47 SHALL also move to DONE and set transmission_complete=1.
REQ-020 Latency SHALL be 48 edges from the LOAD->SEND edge to transmission_complete=1.
REQ-021 In SEND with load_send=0, state, counter, CRC and cmd_out SHALL hold (pause).
REQ-022 In DONE, cmd_out=1 and transmission_complete=1 SHALL hold until reset, reset_wrapper, or enable_pts_wrapper=0.
REQ-023 enable_pts_wrapper=0 in any state SHALL force IDLE, cmd_out=1, transmission_complete=0, and discard any partial frame.
REQ-024 cmd_out SHALL be 1 in IDLE and LOAD (bus idle high).

Reset
REQ-025 reset=1 or reset_wrapper=1 on a rising edge SHALL force IDLE, cmd_out=1, transmission_complete=0, counter=0, CRC=0, shift register=0.
REQ-026 Reset SHALL take priority over all other inputs, including mid-frame, and a mid-frame reset SHALL not resume the aborted frame.

Verification
REQ-027 Load CMD0, arg 0x00000000, then load_send=1 -> 48-bit stream 0x400000000095, transmission_complete=1 on the 48th edge.
REQ-028 Load CMD8, arg 0x000001AA -> stream 0x48000001AA87 (CRC 0x43).
REQ-029 Load CMD17, arg 0 -> stream 0x510000000055 (CRC 0x2A); deassert load_send for 5 cycles at bit 20 -> bit 20 held 6 cycles, stream unchanged, completion at edge 53.
REQ-030 reset_wrapper=1 at bit 30 of a frame -> next edge cmd_out=1, transmission_complete=0, IDLE; new load sends a full correct frame.
REQ-031 enable_pts_wrapper=0 in DONE -> transmission_complete=0 next edge; load_send=1 without a prior load -> cmd_out stays 1 indefinitely.
